// File: rtl/aes_round_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_engine_if
// Description : Handshake/bus bundle for the iterative AES-128 round engine:
//               plaintext input, round-key step/response, ciphertext output.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         key_step;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         err;

    // Upstream producer, key stage and downstream consumer side
    modport master (
        output in_valid, in_data, rk_idx, rk_in, out_ready,
        input  in_ready, key_step, out_valid, out_data, err
    );

    // Engine side
    modport slave (
        input  in_valid, in_data, rk_idx, rk_in, out_ready,
        output in_ready, key_step, out_valid, out_data, err
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_engine (with helper s_box)
// Description : Iterative AES-128 encryption datapath. Accepts a plaintext
//               block, pulls eleven round keys one at a time from the key
//               expansion stage (key_step / rk_idx / rk_in), applies one
//               FIPS-197 round per key and holds the ciphertext until taken.
//               Optional build macro AES_ENG_IDX_CHECK_EN enables checking of
//               the reported round index against the internal round counter.
// Revision    : 1.0 - initial release
// ============================================================================

// AES S-box computed arithmetically: GF(2^8) inverse (x^254) then affine map.
module s_box (
    input  wire logic [7:0] i_x,
    output      logic [7:0] o_y
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240;
    logic [7:0] w_inv;

    // Addition chain for x^254 (= x^-1, and 0 maps to 0)
    assign w_x2   = gf_mul(i_x, i_x);
    assign w_x3   = gf_mul(w_x2, i_x);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_inv  = gf_mul(gf_mul(w_x240, w_x12), w_x2);

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign o_y = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
endmodule

module aes_round_engine (
    input wire logic        clk,
    input wire logic        rst_n,
    aes_round_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KREQ1 = 3'd1,
        KREQ2 = 3'd2,
        APPLY = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] c_last_rnd = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_key;
    logic         r_key_step;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_out_data;
`ifdef AES_ENG_IDX_CHECK_EN
    logic         r_err;
`endif

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_next;

    // SubBytes on every state byte, then ShiftRows as pure rewiring.
    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_sbox
        s_box u_s_box (
            .i_x (r_state[127-8*gi -: 8]),
            .o_y (w_sb[127-8*gi -: 8])
        );
        assign w_sr[127-8*gi -: 8] =
            w_sb[127-8*(4*(((gi/4)+(gi%4))%4)+(gi%4)) -: 8];
    end

    // MixColumns, one column of four bytes at a time
    genvar gc;
    for (gc = 0; gc < 4; gc++) begin : g_mix
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[127-32*gc      -: 8];
        assign w_a1 = w_sr[127-32*gc-8    -: 8];
        assign w_a2 = w_sr[127-32*gc-16   -: 8];
        assign w_a3 = w_sr[127-32*gc-24   -: 8];
        assign w_mc[127-32*gc    -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[127-32*gc-8  -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[127-32*gc-16 -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc[127-32*gc-24 -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    // Round selection: initial whitening, full rounds, final round without MixColumns
    always_comb begin
        w_next = r_state ^ r_key;
        if (r_rnd == c_last_rnd) begin
            w_next = w_sr ^ r_key;
        end else if (r_rnd != 4'd0) begin
            w_next = w_mc ^ r_key;
        end
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rnd       <= 4'd0;
            r_key       <= '0;
            r_key_step  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef AES_ENG_IDX_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state    <= bus.in_data;
                        r_rnd      <= 4'd0;
                        r_key_step <= 1'b1;
                        r_in_ready <= 1'b0;
`ifdef AES_ENG_IDX_CHECK_EN
                        r_err      <= 1'b0;
`endif
                        r_fsm      <= KREQ1;
                    end
                end
                KREQ1: begin
                    r_fsm <= KREQ2;
                end
                KREQ2: begin
                    r_key      <= bus.rk_in;
                    r_key_step <= 1'b0;
`ifdef AES_ENG_IDX_CHECK_EN
                    if (bus.rk_idx != r_rnd) r_err <= 1'b1;
`endif
                    r_fsm      <= APPLY;
                end
                APPLY: begin
                    r_state <= w_next;
                    if (r_rnd != c_last_rnd) begin
                        r_rnd      <= r_rnd + 4'd1;
                        r_key_step <= 1'b1;
                        r_fsm      <= KREQ1;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_next;
                        r_fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.key_step  = r_key_step;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
`ifdef AES_ENG_IDX_CHECK_EN
    assign bus.err       = r_err;
`else
    logic w_unused_idx;
    assign w_unused_idx  = ^bus.rk_idx;
    assign bus.err       = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_engine
// Description : Directed self-checking bench for aes_round_engine using the
//               FIPS-197 C.1 and Appendix B vectors, with a behavioural key
//               expansion stage model. Honors AES_ENG_IDX_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    aes_round_engine_if bus();

    aes_round_engine u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [127:0] c_key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt_c1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_ENG_IDX_CHECK_EN
    localparam logic c_idx_err_exp = 1'b1;
`else
    localparam logic c_idx_err_exp = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- key expansion stage model ----------------
    logic [127:0] rkeys [0:10];
    int           kcnt;
    int           ks_len;
    int           pulses;
    int           bad_width;
    logic         inject;

    assign bus.rk_in  = rkeys[kcnt];
    assign bus.rk_idx = (inject && kcnt == 6) ? 4'd7 : 4'(kcnt);

    // Advance one key per finished key_step pulse; measure pulse widths
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcnt   <= 0;
            ks_len <= 0;
        end else if (bus.key_step) begin
            ks_len <= ks_len + 1;
        end else if (ks_len != 0) begin
            pulses <= pulses + 1;
            if (ks_len != 2) bad_width <= bad_width + 1;
            ks_len <= 0;
            kcnt   <= (kcnt == 10) ? 0 : kcnt + 1;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box via brute-force inverse search, then affine map
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic load_keys(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc   = 8'h01;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]) ^ rc, sbox_ref(t[23:16]),
                     sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_block(input logic [127:0] pt);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk); #1;
            n = n + 1;
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_iready_back"}, 128'(bus.in_ready), 128'(1));
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [127:0] ct, input logic exp_err);
        int n;
        int p0;
        int bw0;
        p0  = pulses;
        bw0 = bad_width;
        start_block(pt);
        check({tag, "_accept"}, 128'(bus.in_ready), 128'(0));
        check({tag, "_kstep_e0"}, 128'(bus.key_step), 128'(1));
        wait_out(n);
        check({tag, "_latency"}, 128'(n), 128'(33));
        check({tag, "_data"}, bus.out_data, ct);
        check({tag, "_err"}, 128'(bus.err), 128'(exp_err));
        check({tag, "_pulses"}, 128'(pulses - p0), 128'(11));
        check({tag, "_width"}, 128'(bad_width - bw0), 128'(0));
        handshake(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bad;
        int p0;
        errors        = 0;
        checks        = 0;
        pulses        = 0;
        bad_width     = 0;
        inject        = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        load_keys(c_key_c1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_key_step", 128'(bus.key_step), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_err", 128'(bus.err), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.1
        run_block("c1", c_pt_c1, c_ct_c1, 1'b0);

        // Appendix B with 10 cycles of backpressure
        load_keys(c_key_b);
        p0 = pulses;
        start_block(c_pt_b);
        wait_out(n);
        check("bp_latency", 128'(n), 128'(33));
        check("bp_data", bus.out_data, c_ct_b);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== c_ct_b || bus.key_step || bus.in_ready)
                bad = bad + 1;
        end
        check("bp_hold", 128'(bad), 128'(0));
        check("bp_pulses", 128'(pulses - p0), 128'(11));
        handshake("bp");

        // Busy input: in_valid held with new data throughout block A
        load_keys(c_key_c1);
        p0 = pulses;
        bus.in_valid = 1'b1;
        bus.in_data  = c_pt_c1;
        @(posedge clk); #1;
        bus.in_data  = c_pt_b;
        check("busy_accept", 128'(bus.in_ready), 128'(0));
        wait_out(n);
        check("busy_latency", 128'(n), 128'(33));
        check("busy_data_a", bus.out_data, c_ct_c1);
        check("busy_pulses_a", 128'(pulses - p0), 128'(11));
        load_keys(c_key_b);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("busy_hs_ovalid", 128'(bus.out_valid), 128'(0));
        check("busy_idle_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("busy_accept_b", 128'(bus.in_ready), 128'(0));
        check("busy_kstep_b", 128'(bus.key_step), 128'(1));
        wait_out(n);
        check("busy_latency_b", 128'(n), 128'(33));
        check("busy_data_b", bus.out_data, c_ct_b);
        handshake("busy_b");

        // Reset during round 5 APPLY, then rerun C.1
        load_keys(c_key_c1);
        start_block(c_pt_c1);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_key_step", 128'(bus.key_step), 128'(0));
        check("mrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mrst_err", 128'(bus.err), 128'(0));
        check("mrst_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("rerun", c_pt_c1, c_ct_c1, 1'b0);

        // Round-index mismatch on round 6, then a clean block clears err
        inject = 1'b1;
        run_block("idx", c_pt_c1, c_ct_c1, c_idx_err_exp);
        inject = 1'b0;
        load_keys(c_key_b);
        run_block("idx_clr", c_pt_b, c_ct_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
